// File: rtl/alu_pkg.sv
// Shared types and flag bit positions for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Single-cycle datapath: add/sub, logic ops and shifts with NZCV flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic             c;
  logic             v;

  assign sub = (op == OP_SUB);
  assign bx  = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign sh  = b[SHW-1:0];

  // The extra bit beside the operand catches the last bit shifted out,
  // and stays 0 for a zero shift amount.
  assign lsl_ext = {1'b0, a} << sh;
  assign lsr_ext = {a, 1'b0} >> sh;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_ORR: result = a | b;
      OP_EOR: result = a ^ b;
      OP_LSL: begin
        result = lsl_ext[WIDTH-1:0];
        c      = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        result = lsr_ext[WIDTH:1];
        c      = lsr_ext[0];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshake FSM, result registers and shift-add multiplier.
//   state | meaning
//   IDLE  | in_ready=1, waiting for an op
//   BUSY  | multiplier iterating, one partial product per cycle
//   DONE  | out_valid=1, result held until out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  alu_state_e       state, state_d;
  alu_op_e          op_in;
  logic             accept;
  logic             mul_last;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

  assign op_in = alu_op_e'(ALUControl);

  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .a      (a),
    .b      (b),
    .op     (op_in),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    mul_last = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = (op_in == OP_MUL) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt == CNT_LAST) begin
          mul_last = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Accumulator wraps at WIDTH bits, so only the low half of the product survives.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      Result   <= '0;
      ALUFlags <= '0;
    end else if (accept) begin
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      if (op_in != OP_MUL) begin
        Result   <= core_result;
        ALUFlags <= core_flags;
      end
    end else if (state == BUSY) begin
      cnt    <= cnt + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      if (mul_last) begin
        Result           <= acc_next;
        ALUFlags         <= '0;
        ALUFlags[FLAG_N] <= acc_next[WIDTH-1];
        ALUFlags[FLAG_Z] <= (acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, random ops against a model, handshake corners.
module tb_alu_mc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    ALUControl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  Result;
  logic [3:0]    ALUFlags;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   fl;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference built from plain arithmetic on 64-bit values.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [3:0] f);
    logic [63:0] wide;
    logic c, v;
    int sh;
    sh = int'(y[4:0]);
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      3'd0: begin
        wide = {32'b0, x} + {32'b0, y};
        r = wide[31:0];
        c = wide[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        r = x << sh;
        c = (sh != 0) ? x[32-sh] : 1'b0;
      end
      3'd6: begin
        r = x >> sh;
        c = (sh != 0) ? x[sh-1] : 1'b0;
      end
      default: begin
        wide = {32'b0, x} * {32'b0, y};
        r = wide[31:0];
      end
    endcase
    f = {r[31], (r == 0), c, v};
  endfunction

  // Issues one op, waits for the result, completes the output handshake.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic [3:0] f, output int lat,
                        output logic rdy_seen);
    int n;
    @(negedge clk);
    a = x; b = y; ALUControl = op; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ALUControl = 3'($urandom);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    r = Result;
    f = ALUFlags;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r, er;
    logic [3:0]   f, ef;
    logic         rs;
    int           lat;
    int           acc_cyc[$];
    logic [W-1:0] got_r[$];
    logic [3:0]   got_f[$];
    int           stale;

    tbl[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
    tbl[1]  = '{3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
    tbl[2]  = '{3'd5, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0010};
    tbl[3]  = '{3'd6, 32'h00000001, 32'h00000001, 32'h00000000, 4'b0110};
    tbl[4]  = '{3'd6, 32'h12345678, 32'h00000000, 32'h12345678, 4'b0000};
    tbl[5]  = '{3'd4, 32'h0000F0F0, 32'h0000FFFF, 32'h00000F0F, 4'b0000};
    tbl[6]  = '{3'd7, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b1000};
    tbl[7]  = '{3'd2, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 4'b0000};
    tbl[8]  = '{3'd3, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100};
    tbl[9]  = '{3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000};
    tbl[10] = '{3'd5, 32'h00000001, 32'h0000001F, 32'h80000000, 4'b1000};
    tbl[11] = '{3'd6, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
    tbl[12] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
    tbl[13] = '{3'd5, 32'h00000003, 32'h00000021, 32'h00000006, 4'b0000};
    tbl[14] = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", Result, 0);
    chk("rst_flags", ALUFlags, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat, rs);
      chk($sformatf("vec%0d_result", i), r, tbl[i].res);
      chk($sformatf("vec%0d_flags", i), f, tbl[i].fl);
      chk($sformatf("vec%0d_latency", i), lat, (tbl[i].op == 3'd7) ? W + 1 : 1);
      if (tbl[i].op == 3'd7) chk($sformatf("vec%0d_in_ready_low", i), rs, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] x, y;
      op = 3'($urandom);
      x = $urandom;
      y = (i % 3 == 0) ? W'($urandom_range(0, 40)) : $urandom;
      model(op, x, y, er, ef);
      run_op(op, x, y, r, f, lat, rs);
      chk($sformatf("rnd%0d_op%0d_result", i, op), r, er);
      chk($sformatf("rnd%0d_op%0d_flags", i, op), f, ef);
    end

    // Reset during a multiply: nothing stale may surface afterwards.
    @(negedge clk);
    a = 32'h1234; b = 32'h5678; ALUControl = 3'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_in_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", Result, 0);
    chk("mid_rst_flags", ALUFlags, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (45) begin
      @(negedge clk);
      if (out_valid || Result != 0) stale++;
    end
    chk("mid_rst_no_stale", stale, 0);
    chk("mid_rst_in_ready_after", in_ready, 1);

    // Backpressure: result held while out_ready is low, new inputs ignored.
    @(negedge clk);
    a = 32'hF0F0; b = 32'hFFFF; ALUControl = 3'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 32'hDEAD; b = 32'hBEEF; ALUControl = 3'd0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_result", i), Result, 32'h0F0F);
      chk($sformatf("bp%0d_out_valid", i), out_valid, 1);
      chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", out_valid, 0);
    chk("bp_idle", in_ready, 1);

    // Back-to-back with in_valid held and out_ready tied high.
    a = 32'd3; b = 32'd4; ALUControl = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid && out_ready) begin
        got_r.push_back(Result);
        got_f.push_back(ALUFlags);
      end
      if (in_valid && in_ready) acc_cyc.push_back(c);
      @(negedge clk);
      if (acc_cyc.size() == 1) begin
        a = 32'd1; b = 32'd2; ALUControl = 3'd1;
      end else if (acc_cyc.size() >= 2) begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 2);
    chk("b2b_results", got_r.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 2);
    if (got_r.size() == 2) begin
      model(3'd0, 32'd3, 32'd4, er, ef);
      chk("b2b_first_result", got_r[0], er);
      chk("b2b_first_flags", got_f[0], ef);
      model(3'd1, 32'd1, 32'd2, er, ef);
      chk("b2b_second_result", got_r[1], er);
      chk("b2b_second_flags", got_f[1], ef);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle 2-bit-control ALU.
- Adds XOR, logical shifts and an iterative shift-add multiplier, configurable datapath width, and valid/ready handshakes on both sides.
- Registers Result and NZCV flags.
- Sits between the register-file read stage and writeback in the multi-cycle core. Flags feed the condition-check unit.

Parameters:
- WIDTH, 32, datapath width in bits (>= 8, power of two)
- SHW, $clog2(WIDTH), shift-amount field width taken from b[SHW-1:0]

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  block can accept an op
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ALUControl  in  3  op select (encoding under Behaviour)
- out_valid  out  1  Result/ALUFlags valid
- out_ready  in  1  consumer accepts the result
- Result  out  WIDTH  registered result
- ALUFlags  out  4  registered {N,Z,C,V}

Behaviour:
- Op encoding:
  - 000 ADD, 001 SUB (a + ~b + 1), 010 AND, 011 ORR, 100 EOR
  - 101 LSL by b[SHW-1:0], 110 LSR by b[SHW-1:0]
  - 111 MUL (low WIDTH bits of a*b, unsigned/signed identical)
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a, b and op. MUL goes to BUSY; every other op goes to DONE.
  - BUSY: one shift-add iteration per cycle, with a counter counting 0..WIDTH-1. When the counter reaches WIDTH-1, go to DONE.
  - DONE: out_valid=1. Result and flags are held stable. When out_ready=1, go to IDLE.
- Latency:
  - Non-MUL ops: out_valid rises on the clock edge after acceptance.
  - MUL: out_valid rises WIDTH+1 edges after acceptance.
  - Minimum spacing between accepted ops is 2 cycles.
- Handshake:
  - in_ready = (state==IDLE). No input is accepted in BUSY or DONE.
  - Inputs are sampled only at the accept edge. Later changes to a, b or ALUControl have no effect.
  - out_valid never drops without out_ready.
- Flags:
  - N = Result[WIDTH-1] for every op.
  - Z = (Result==0) for every op.
  - ADD/SUB: C = carry out of bit WIDTH-1. V = ~(a[W-1]^b[W-1]^sub) & (a[W-1]^sum[W-1]).
  - SUB carry follows the ARM convention (C=1 means no borrow).
  - LSL: C = last bit shifted out, i.e. a[WIDTH-sh].
  - LSR: C = a[sh-1].
  - Shift by 0: C=0, Result=a.
  - AND/ORR/EOR/MUL: C=0, V=0.
  - V=0 for shifts.
- Arithmetic:
  - Sum computed at WIDTH+1 bits.
  - Multiplier: accumulator of WIDTH bits with wrap discarded. Multiplicand shifts left and multiplier shifts right each iteration.
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; Result=0, ALUFlags=0, out_valid=0; iteration counter cleared.
  - in_ready reads 1 once state is IDLE.
  - Reset in BUSY or DONE aborts the op. No result is delivered.
- Simultaneous events: the DONE->IDLE transition and a new in_valid in the same cycle do not both fire. The new op is accepted in the following IDLE cycle.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e (3-bit op enum)
  - alu_state_e {IDLE, BUSY, DONE}
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module alu_core: the combinational single-cycle datapath (add/sub, logic, shifts, flags), parametrised by WIDTH.
- alu_mc contains the FSM, the operand/result registers and the iterative multiplier.

Test Plan:
- Reset mid-op: assert reset_n=0 during MUL BUSY -> out_valid=0, Result=0, ALUFlags=0, in_ready=1 after release; no stale result ever appears.
- Add/sub flags (WIDTH=32):
  - ADD 0x7FFFFFFF+1 -> Result=0x80000000, flags 1001 after 1 cycle.
  - SUB 5-5 -> Result=0, flags 0110.
- Shifts:
  - LSL a=0x80000001, b=1 -> Result=0x00000002, C=1.
  - LSR a=0x1, b=1 -> Result=0, flags 0110.
  - LSR with b=0 -> Result=a, C=0.
- MUL 0xFFFF*0x10001 -> Result=0xFFFFFFFF, flags 1000; out_valid exactly 33 edges after accept; in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after an EOR 0xF0F0^0xFFFF -> Result=0x0F0F stable, out_valid stays 1; in_valid during this window is ignored.
- Back-to-back: issue 2 ops with in_valid held and out_ready tied 1 -> accepts spaced 2 cycles apart; results returned in issue order with correct flags.
